// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

    localparam int DEF_TIMEOUT_CYC = 32'd65536;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    logic [IDX_W-1:0] cand_s;

    // Scan from the farthest offset down so the nearest set request wins
    always_comb begin
        idx    = {IDX_W{1'b0}};
        found  = 1'b0;
        cand_s = {IDX_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (req[cand_s]) begin
                idx   = cand_s;
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte-stream
// requesters, with per-packet grant lock and per-byte transmitter timeout.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_W      = 8,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int IDX_W       = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          ack,
    input  logic                        tx_rdy,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_done,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_idx,
    output logic                        timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    // Outputs are registered, so the abort is decided one cycle before the
    // counter would show TIMEOUT_CYC-1; the error pulse then lands on that count.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYC - 32'd2);

    sched_state_t         state_r;
    sched_state_t         next_state_s;
    logic [IDX_W-1:0]     ptr_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 last_r;

    logic [IDX_W-1:0]     pick_idx_s;
    logic                 pick_found_s;
    logic                 grant_req_s;
    logic                 issue_s;
    logic                 release_s;
    logic                 timeout_s;

    logic [NUM_REQ-1:0]   ack_r;
    logic                 tx_start_r;
    logic [DATA_W-1:0]    tx_data_r;
    logic                 grant_valid_r;
    logic [IDX_W-1:0]     grant_idx_r;
    logic                 timeout_err_r;

    logic [NUM_REQ-1:0]   ack_nxt_s;
    logic                 tx_start_nxt_s;
    logic [DATA_W-1:0]    tx_data_nxt_s;
    logic                 grant_valid_nxt_s;
    logic [IDX_W-1:0]     grant_idx_nxt_s;
    logic                 timeout_err_nxt_s;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(NUM_REQ - 32'd1)) begin
            return {IDX_W{1'b0}};
        end else begin
            return i + IDX_W'(32'd1);
        end
    endfunction

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_r),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    assign grant_req_s = req[grant_idx_r];

    // State, pointer, timeout counter and last-byte flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            ptr_r   <= {IDX_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            last_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (release_s) begin
                ptr_r <= wrap_inc(grant_idx_r);
            end
            if (issue_s || (state_r != WAIT_DONE)) begin
                cnt_r <= {CNT_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_W'(32'd1);
            end
            if (issue_s) begin
                last_r <= req_last[grant_idx_r];
            end
        end
    end

    // Next-state and handshake decisions
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        release_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    next_state_s = SEND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SEND: begin
                if (!grant_req_s) begin
                    release_s    = 1'b1;
                    next_state_s = IDLE;
                end else if (tx_rdy) begin
                    issue_s      = 1'b1;
                    next_state_s = WAIT_DONE;
                end else begin
                    next_state_s = SEND;
                end
            end
            WAIT_DONE: begin
                // Completion wins over a simultaneous terminal count
                if (tx_done) begin
                    if (last_r || !grant_req_s) begin
                        release_s    = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = SEND;
                    end
                end else if (cnt_r == CNT_TERM) begin
                    timeout_s    = 1'b1;
                    release_s    = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT_DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Next values for the registered outputs
    always_comb begin
        ack_nxt_s         = {NUM_REQ{1'b0}};
        tx_start_nxt_s    = issue_s;
        tx_data_nxt_s     = tx_data_r;
        grant_valid_nxt_s = (next_state_s != IDLE);
        grant_idx_nxt_s   = grant_idx_r;
        timeout_err_nxt_s = timeout_s;
        if (issue_s) begin
            ack_nxt_s     = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_r;
            tx_data_nxt_s = req_data[grant_idx_r * DATA_W +: DATA_W];
        end else begin
            ack_nxt_s     = {NUM_REQ{1'b0}};
            tx_data_nxt_s = tx_data_r;
        end
        if ((state_r == IDLE) && pick_found_s) begin
            grant_idx_nxt_s = pick_idx_s;
        end else begin
            grant_idx_nxt_s = grant_idx_r;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_r         <= {NUM_REQ{1'b0}};
            tx_start_r    <= 1'b0;
            tx_data_r     <= {DATA_W{1'b0}};
            grant_valid_r <= 1'b0;
            grant_idx_r   <= {IDX_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            ack_r         <= ack_nxt_s;
            tx_start_r    <= tx_start_nxt_s;
            tx_data_r     <= tx_data_nxt_s;
            grant_valid_r <= grant_valid_nxt_s;
            grant_idx_r   <= grant_idx_nxt_s;
            timeout_err_r <= timeout_err_nxt_s;
        end
    end

    assign ack         = ack_r;
    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign grant_valid = grant_valid_r;
    assign grant_idx   = grant_idx_r;
    assign timeout_err = timeout_err_r;

endmodule
